// File: rtl/sa_pkg.sv
// Shared constants and helpers for the systolic-array datapath blocks.
package sa_pkg;

  localparam int unsigned DefAccW  = 8;
  localparam int unsigned DefDataW = 8;
  localparam int unsigned DefNCols = 4;

  // LSB of column col inside a packed column bus.
  function automatic int unsigned col_lsb(input int unsigned col, input int unsigned acc_w);
    return col * acc_w;
  endfunction

  // FIFO entry is {last, data}.
  function automatic int unsigned entry_w(input int unsigned n_cols, input int unsigned acc_w);
    return n_cols * acc_w + 1;
  endfunction

  localparam int unsigned DefEntryW = entry_w(DefNCols, DefAccW);

endpackage

// File: rtl/sa_sync_fifo.sv
// Single-clock FIFO; a push while full is accepted when a pop happens in the same cycle.
module sa_sync_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [Width-1:0] wdata,
  output logic [Width-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == (PtrW + 1)'(Depth));
  assign empty   = (count_q == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (PtrW + 1)'(1);
      2'b01:   count_d = count_q - (PtrW + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clear) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      // Depth is a power of two, so pointers wrap naturally.
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(Depth); i++) mem_q[i] <= '0;
    end else if (do_push && !clear) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

endmodule

// File: rtl/sa_psum_collector.sv
// De-skews the bottom-row psums of the systolic array into aligned rows and
// buffers them for a valid/ready writer; overflow is flagged, never back-pressured.
module sa_psum_collector
  import sa_pkg::*;
#(
  parameter int unsigned N_COLS     = 4,
  parameter int unsigned ACC_W      = DefAccW,
  parameter int unsigned N_ROWS     = 4,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    in_valid,
  input  logic [N_COLS*ACC_W-1:0] psum_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [N_COLS*ACC_W-1:0] out_data,
  output logic                    out_last,
  output logic                    tile_done,
  output logic                    overflow
);

  localparam int unsigned EntryW = entry_w(N_COLS, ACC_W);
  localparam int unsigned Stages = N_COLS - 1;
  localparam int unsigned CntW   = (N_ROWS > 1) ? $clog2(N_ROWS) : 1;

  logic [N_COLS*ACC_W-1:0] aligned;
  logic [Stages-1:0]       vld_q;
  logic                    aligned_valid;
  logic [CntW-1:0]         row_cnt_q, row_cnt_d;
  logic                    is_last;
  logic                    tile_done_q, overflow_q;
  logic                    fifo_full, fifo_empty, pop;
  logic [EntryW-1:0]       fifo_rdata;

  // Column c waits N_COLS-1-c cycles so every column lands on the same edge.
  for (genvar c = 0; c < int'(N_COLS); c++) begin : g_col
    localparam int unsigned S   = N_COLS - 1 - c;
    localparam int unsigned Lsb = col_lsb(c, ACC_W);
    if (S == 0) begin : g_pass
      assign aligned[Lsb +: ACC_W] = psum_in[Lsb +: ACC_W];
    end else begin : g_dly
      logic [ACC_W-1:0] stg_q [S];
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < int'(S); i++) stg_q[i] <= '0;
        end else begin
          stg_q[0] <= psum_in[Lsb +: ACC_W];
          for (int i = 1; i < int'(S); i++) stg_q[i] <= stg_q[i-1];
        end
      end
      assign aligned[Lsb +: ACC_W] = stg_q[S-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
    end else if (clear) begin
      vld_q <= '0;
    end else begin
      vld_q[0] <= in_valid;
      for (int i = 1; i < int'(Stages); i++) vld_q[i] <= vld_q[i-1];
    end
  end

  assign aligned_valid = vld_q[Stages-1];
  assign pop           = out_valid && out_ready;
  assign is_last       = (row_cnt_q == CntW'(N_ROWS - 1));

  // Dropped rows still advance the counter so tile framing survives overflow.
  always_comb begin
    row_cnt_d = row_cnt_q;
    if (aligned_valid) row_cnt_d = is_last ? '0 : row_cnt_q + CntW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_cnt_q   <= '0;
      tile_done_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else if (clear) begin
      row_cnt_q   <= '0;
      tile_done_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      row_cnt_q   <= row_cnt_d;
      tile_done_q <= aligned_valid && is_last;
      overflow_q  <= overflow_q | (aligned_valid && fifo_full && !pop);
    end
  end

  sa_sync_fifo #(
    .Width (EntryW),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .push  (aligned_valid),
    .pop   (pop),
    .wdata ({is_last, aligned}),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign out_valid = !fifo_empty;
  assign out_last  = fifo_rdata[EntryW-1];
  assign out_data  = fifo_rdata[EntryW-2:0];
  assign tile_done = tile_done_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_sa_psum_collector.sv
// Directed bench for sa_psum_collector with N_COLS=4, ACC_W=8, N_ROWS=4, FIFO_DEPTH=4.
module tb_sa_psum_collector;

  logic        clk = 1'b0;
  logic        rst, clear, in_valid, out_ready;
  logic [31:0] psum_in, out_data;
  logic        out_valid, out_last, tile_done, overflow;

  int passed = 0;
  int total  = 0;

  logic [7:0]  row_val [8][4];
  logic [31:0] cap_data [$];
  logic        cap_last [$];
  int          td_cnt, td_t, vld_cycles, first_vld_t;

  always #5 clk = ~clk;

  sa_psum_collector #(
    .N_COLS     (4),
    .ACC_W      (8),
    .N_ROWS     (4),
    .FIFO_DEPTH (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .in_valid  (in_valid),
    .psum_in   (psum_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .tile_done (tile_done),
    .overflow  (overflow)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic fill_rows(input int base);
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 4; c++) row_val[r][c] = 8'(base + r * 10 + c);
  endtask

  // Skewed bus at cycle t for n rows starting at cycle 0.
  function automatic logic [31:0] bus_at(input int t, input int n);
    logic [31:0] b;
    b = '0;
    for (int c = 0; c < 4; c++) begin
      int r;
      r = t - c;
      if (r >= 0 && r < n) b[c*8 +: 8] = row_val[r][c];
    end
    return b;
  endfunction

  task automatic run_stream(input int n, input int extra);
    cap_data.delete();
    cap_last.delete();
    td_cnt = 0; td_t = -1; vld_cycles = 0; first_vld_t = -1;
    for (int t = 0; t < n + 3 + extra; t++) begin
      in_valid = (t < n);
      psum_in  = bus_at(t, n);
      tick();
      if (out_valid) begin
        vld_cycles++;
        if (first_vld_t < 0) first_vld_t = t;
      end
      if (out_valid && out_ready) begin
        cap_data.push_back(out_data);
        cap_last.push_back(out_last);
      end
      if (tile_done) begin
        td_cnt++;
        td_t = t;
      end
    end
    in_valid = 1'b0;
    psum_in  = '0;
  endtask

  task automatic drain(input int cycles);
    cap_data.delete();
    cap_last.delete();
    out_ready = 1'b1;
    for (int i = 0; i < cycles; i++) begin
      if (out_valid) begin
        cap_data.push_back(out_data);
        cap_last.push_back(out_last);
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0; psum_in = '0;
    #2;
    total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %0b want 0", out_valid); else passed++;
    total++; if (out_data !== 32'h0) $display("FAIL reset_out_data got %h want 0", out_data); else passed++;
    total++; if (out_last !== 1'b0) $display("FAIL reset_out_last got %0b want 0", out_last); else passed++;
    total++; if (tile_done !== 1'b0) $display("FAIL reset_tile_done got %0b want 0", tile_done); else passed++;
    total++; if (overflow !== 1'b0) $display("FAIL reset_overflow got %0b want 0", overflow); else passed++;
    tick();
    tick();
    rst = 1'b0;
    tick();
    total++; if (out_valid !== 1'b0) $display("FAIL post_reset_valid got %0b want 0", out_valid); else passed++;
  endtask

  task automatic test_single_row();
    row_val[0][0] = 8'd6; row_val[0][1] = 8'd12; row_val[0][2] = 8'd19; row_val[0][3] = 8'd42;
    out_ready = 1'b1;
    run_stream(1, 2);
    total++; if (cap_data.size() !== 1) $display("FAIL single_count got %0d want 1", cap_data.size()); else passed++;
    if (cap_data.size() >= 1) begin
      total++; if (cap_data[0] !== 32'h2A130C06) $display("FAIL single_data got %h want 2a130c06", cap_data[0]); else passed++;
      total++; if (cap_last[0] !== 1'b0) $display("FAIL single_last got %0b want 0", cap_last[0]); else passed++;
    end
    total++; if (vld_cycles !== 1) $display("FAIL single_valid_cycles got %0d want 1", vld_cycles); else passed++;
    total++; if (first_vld_t !== 3) $display("FAIL single_latency got %0d want 3", first_vld_t); else passed++;
  endtask

  task automatic test_full_tile();
    logic [31:0] exp_d [4];
    exp_d[0] = 32'h03020100; exp_d[1] = 32'h0D0C0B0A;
    exp_d[2] = 32'h17161514; exp_d[3] = 32'h21201F1E;
    do_clear();
    fill_rows(0);
    out_ready = 1'b1;
    run_stream(4, 2);
    total++; if (cap_data.size() !== 4) $display("FAIL tile_count got %0d want 4", cap_data.size()); else passed++;
    for (int r = 0; r < 4; r++) begin
      if (r < cap_data.size()) begin
        total++; if (cap_data[r] !== exp_d[r]) $display("FAIL tile_data row %0d got %h want %h", r, cap_data[r], exp_d[r]); else passed++;
        total++; if (cap_last[r] !== (r == 3)) $display("FAIL tile_last row %0d got %0b want %0b", r, cap_last[r], r == 3); else passed++;
      end
    end
    total++; if (td_cnt !== 1) $display("FAIL tile_done_count got %0d want 1", td_cnt); else passed++;
    total++; if (td_t !== 6) $display("FAIL tile_done_cycle got %0d want 6", td_t); else passed++;
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_d [4];
    exp_d[0] = 32'h03020100; exp_d[1] = 32'h0D0C0B0A;
    exp_d[2] = 32'h17161514; exp_d[3] = 32'h21201F1E;
    do_clear();
    fill_rows(0);
    out_ready = 1'b0;
    run_stream(5, 1);
    total++; if (overflow !== 1'b1) $display("FAIL bp_overflow got %0b want 1", overflow); else passed++;
    total++; if (out_valid !== 1'b1) $display("FAIL bp_valid got %0b want 1", out_valid); else passed++;
    tick();
    tick();
    total++; if (out_data !== 32'h03020100) $display("FAIL bp_stable_data got %h want 03020100", out_data); else passed++;
    drain(6);
    total++; if (cap_data.size() !== 4) $display("FAIL bp_drain_count got %0d want 4", cap_data.size()); else passed++;
    for (int r = 0; r < 4; r++) begin
      if (r < cap_data.size()) begin
        total++; if (cap_data[r] !== exp_d[r]) $display("FAIL bp_data row %0d got %h want %h", r, cap_data[r], exp_d[r]); else passed++;
        total++; if (cap_last[r] !== (r == 3)) $display("FAIL bp_last row %0d got %0b want %0b", r, cap_last[r], r == 3); else passed++;
      end
    end
    total++; if (overflow !== 1'b1) $display("FAIL bp_overflow_sticky got %0b want 1", overflow); else passed++;
    total++; if (out_valid !== 1'b0) $display("FAIL bp_empty got %0b want 0", out_valid); else passed++;
    do_clear();
    total++; if (overflow !== 1'b0) $display("FAIL bp_overflow_clear got %0b want 0", overflow); else passed++;
  endtask

  task automatic test_full_pop();
    logic [31:0] exp_d [4];
    logic        exp_l [4];
    exp_d[0] = 32'h0D0C0B0A; exp_d[1] = 32'h17161514;
    exp_d[2] = 32'h21201F1E; exp_d[3] = 32'h88776655;
    exp_l[0] = 1'b0; exp_l[1] = 1'b0; exp_l[2] = 1'b1; exp_l[3] = 1'b0;
    fill_rows(0);
    out_ready = 1'b0;
    run_stream(4, 1);
    row_val[4][0] = 8'h55; row_val[4][1] = 8'h66; row_val[4][2] = 8'h77; row_val[4][3] = 8'h88;
    for (int t = 0; t < 4; t++) begin
      in_valid = (t == 0);
      psum_in = '0;
      psum_in[t*8 +: 8] = row_val[4][t];
      out_ready = (t == 3);
      tick();
    end
    in_valid = 1'b0; psum_in = '0; out_ready = 1'b0;
    total++; if (overflow !== 1'b0) $display("FAIL fp_overflow got %0b want 0", overflow); else passed++;
    total++; if (out_data !== 32'h0D0C0B0A) $display("FAIL fp_head got %h want 0d0c0b0a", out_data); else passed++;
    drain(6);
    total++; if (cap_data.size() !== 4) $display("FAIL fp_count got %0d want 4", cap_data.size()); else passed++;
    for (int r = 0; r < 4; r++) begin
      if (r < cap_data.size()) begin
        total++; if (cap_data[r] !== exp_d[r]) $display("FAIL fp_data row %0d got %h want %h", r, cap_data[r], exp_d[r]); else passed++;
        total++; if (cap_last[r] !== exp_l[r]) $display("FAIL fp_last row %0d got %0b want %0b", r, cap_last[r], exp_l[r]); else passed++;
      end
    end
    total++; if (overflow !== 1'b0) $display("FAIL fp_overflow_end got %0b want 0", overflow); else passed++;
  endtask

  task automatic test_clear_mid_skew();
    logic [31:0] exp_d [4];
    int          seen;
    exp_d[0] = 32'h67666564; exp_d[1] = 32'h71706F6E;
    exp_d[2] = 32'h7B7A7978; exp_d[3] = 32'h85848382;
    seen = 0;
    out_ready = 1'b1;
    for (int t = 0; t < 7; t++) begin
      in_valid = (t == 0);
      psum_in = '0;
      if (t < 4) psum_in[t*8 +: 8] = 8'(t + 1);
      clear = (t == 2);
      tick();
      if (out_valid) seen++;
    end
    clear = 1'b0; psum_in = '0;
    total++; if (seen !== 0) $display("FAIL cms_no_output got %0d want 0", seen); else passed++;
    fill_rows(100);
    run_stream(4, 2);
    total++; if (cap_data.size() !== 4) $display("FAIL cms_count got %0d want 4", cap_data.size()); else passed++;
    for (int r = 0; r < 4; r++) begin
      if (r < cap_data.size()) begin
        total++; if (cap_data[r] !== exp_d[r]) $display("FAIL cms_data row %0d got %h want %h", r, cap_data[r], exp_d[r]); else passed++;
        total++; if (cap_last[r] !== (r == 3)) $display("FAIL cms_last row %0d got %0b want %0b", r, cap_last[r], r == 3); else passed++;
      end
    end
    total++; if (td_cnt !== 1) $display("FAIL cms_tile_done got %0d want 1", td_cnt); else passed++;
  endtask

  task automatic test_async_reset();
    fill_rows(0);
    out_ready = 1'b0;
    run_stream(5, 1);
    out_ready = 1'b1;
    tick();
    total++; if (out_data !== 32'h0D0C0B0A) $display("FAIL ar_pre_data got %h want 0d0c0b0a", out_data); else passed++;
    #2;
    rst = 1'b1;
    #1;
    total++; if (out_valid !== 1'b0) $display("FAIL ar_valid got %0b want 0", out_valid); else passed++;
    total++; if (out_data !== 32'h0) $display("FAIL ar_data got %h want 0", out_data); else passed++;
    total++; if (out_last !== 1'b0) $display("FAIL ar_last got %0b want 0", out_last); else passed++;
    total++; if (overflow !== 1'b0) $display("FAIL ar_overflow got %0b want 0", overflow); else passed++;
    total++; if (tile_done !== 1'b0) $display("FAIL ar_tile_done got %0b want 0", tile_done); else passed++;
    tick();
    rst = 1'b0;
    tick();
    total++; if (out_valid !== 1'b0) $display("FAIL ar_after_valid got %0b want 0", out_valid); else passed++;
  endtask

  initial begin
    test_reset();
    test_single_row();
    test_full_tile();
    test_backpressure();
    test_full_pop();
    test_clear_mid_skew();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
